logic_op_sequencer: RTL and testbench
=====================================

# logic_op_sequencer

Upstream command stage for the one-hot-select logic unit (NAND/NOR/XOR/XNOR). Accepts `{op, a, b}` commands over a valid/ready handshake and buffers them in a small FIFO. Issues one command at a time to the logic unit as registered `A`, `B` and one-hot `Sel`, samples the unit's `Y` one cycle later, and presents the result downstream with backpressure.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of completed-operation counter.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  command present
- `in_ready`  out  1  FIFO can accept; equals `!full`
- `in_op`  in  2  0=NAND, 1=NOR, 2=XOR, 3=XNOR
- `in_a`, `in_b`  in  1  operands
- `A`, `B`  out  1  registered operands to logic unit
- `Sel`  out  4  registered one-hot select (`1<<op`); 4'b0000 when idle
- `Y`  in  1  logic-unit result; combinational from `A`/`B`/`Sel`
- `res_valid`  out  1  result held
- `res_ready`  in  1  downstream accepts result
- `res_y`  out  1  captured `Y`
- `res_op`  out  2  op of captured result
- `ops_done`  out  CNT_W  count of accepted results; wraps

## Operation
- Push: on a clock edge with `in_valid && in_ready`, write `{in_op,in_a,in_b}` at the write pointer.
- `in_ready` depends only on `full`. A pop in the same cycle does not free a slot for that cycle's push.
- FIFO: pointers `$clog2(DEPTH)+1` bits. Full when MSBs differ and low bits are equal. Pointers wrap modulo 2·DEPTH. No fall-through: an entry becomes visible the cycle after its push.
- FSM states:
  - IDLE: `Sel`=0. If FIFO is non-empty: pop, load `A`/`B`/`Sel`, go to DRIVE.
  - DRIVE: exactly one cycle. At the edge, capture `res_y<=Y` and `res_op<=op`, set `res_valid`, clear `Sel`/`A`/`B`, go to RESULT.
  - RESULT: hold `res_*` stable while `res_ready`=0. On `res_ready`=1: `ops_done++`. Then if FIFO is non-empty, pop and go to DRIVE, dropping `res_valid` in the same edge. Otherwise clear `res_valid` and go to IDLE.
- Only one command is in flight. Peak throughput is one result per 2 cycles.
- Push and pop on the same edge are both honoured; occupancy is unchanged.
- `ops_done` wraps from 2^CNT_W−1 to 0 without flagging.
- Reset: asynchronous and immediate, including mid-DRIVE or mid-RESULT. The in-flight command and FIFO contents are discarded.

## Timing
- Reset values:
  - `A`=`B`=0, `Sel`=4'b0000
  - `res_valid`=0, `res_y`=0, `res_op`=0, `ops_done`=0
  - `in_ready`=1, FSM in IDLE, pointers 0
- Latency, with `res_ready` held 1:
  - Push accepted at edge e0.
  - `Sel` driven after e1.
  - `res_valid` high after e2.
  - Result accepted at e3.
  - Next `Sel` driven after e3.
- `Sel` is never non-zero in two consecutive cycles.
- `Sel` is always zero or exactly one-hot.
- `res_*` must not change while `res_valid && !res_ready`.

## Structure
- Package `logic_seq_pkg`:
  - `op_e` enum (OP_NAND, OP_NOR, OP_XOR, OP_XNOR)
  - `state_e` (IDLE, DRIVE, RESULT)
  - `cmd_t` packed struct `{op,a,b}`
  - function `op2sel(op_e)` returning the 4-bit one-hot
- Sub-module `logic_cmd_fifo`: parameterised synchronous FIFO with push/pop/full/empty, holding `cmd_t`.
- Top: FSM and output registers only.

## Test plan
- Single command: op=2 (XOR), a=1, b=0, `res_ready`=1.
  - `Sel`=4'b0100, `A`=1, `B`=0 for one cycle, 2 cycles after push.
  - `res_y`=1, `res_op`=2 one cycle later.
  - `ops_done`=1.
- All ops, a=1, b=1, in order 0..3.
  - `Sel` sequence 0001, 0010, 0100, 1000.
  - `res_y` sequence 0, 0, 0, 1.
  - `Sel` zero between issues.
- Full FIFO: push 5 commands back-to-back with `res_ready`=0.
  - 1 command is in flight and 4 are queued, so `in_ready` drops after the 5th push.
  - The 6th push is refused.
  - `res_*` is stable for 10 cycles.
  - After releasing `res_ready`, all 5 results emerge in order.
- Backpressure with a waiting entry: `res_ready` low 3 cycles while the FIFO holds 1 entry.
  - Entry is not popped until the accept edge.
  - On that edge `Sel` goes one-hot and `res_valid` drops.
- Reset mid-DRIVE: assert `rst_n`=0 while `Sel`=4'b0010.
  - All outputs return to reset values asynchronously.
  - After release, no result emerges from the discarded commands.
- Counter wrap: `CNT_W`=2, 5 results accepted → `ops_done`=1.

Source files
------------

// File: rtl/logic_seq_pkg.sv
// rtl/logic_seq_pkg.sv - shared types and helpers for the logic-op command sequencer
//
// Purpose: operation and FSM encodings, the queued command record, and the
//          op-to-select decoder.

package logic_seq_pkg;

    typedef enum logic [1:0] {
        OP_NAND = 2'd0,
        OP_NOR  = 2'd1,
        OP_XOR  = 2'd2,
        OP_XNOR = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        RESULT = 2'd2
    } state_e;

    typedef struct packed {
        op_e  op;
        logic a;
        logic b;
    } cmd_t;

    // One-hot select for the logic unit: bit position equals the op code.
    function automatic logic [3:0] op2sel(input op_e op);
        return 4'b0001 << op;
    endfunction

endpackage

// File: rtl/logic_cmd_fifo.sv
// rtl/logic_cmd_fifo.sv - synchronous command FIFO without fall-through
//
// Purpose: holds queued cmd_t entries between the upstream handshake and the FSM.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push_i, wdata_i     write strobe and entry (ignored when full)
//   pop_i               read strobe (ignored when empty)
//   rdata_o             head entry, valid while !empty_o
//   full_o, empty_o     occupancy flags

module logic_cmd_fifo
    import logic_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  cmd_t wdata_i,
    input  logic pop_i,
    output cmd_t rdata_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    cmd_t        mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/logic_op_sequencer.sv
// rtl/logic_op_sequencer.sv - issues queued logic commands to a one-hot-select logic unit
//
// Purpose: buffers {op,a,b} commands, drives A/B/Sel for one cycle per command,
//          captures Y and presents it downstream with backpressure.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_op/a/b     command handshake (in_ready = FIFO not full)
//   A, B, Sel                       registered operands and one-hot select
//   Y                               logic-unit result (combinational from A/B/Sel)
//   res_valid/res_ready/res_y/op    result handshake
//   ops_done                        wrapping count of accepted results

module logic_op_sequencer
    import logic_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_a,
    input  logic             in_b,
    output logic             A,
    output logic             B,
    output logic [3:0]       Sel,
    input  logic             Y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_y,
    output logic [1:0]       res_op,
    output logic [CNT_W-1:0] ops_done
);

    state_e           state_q, state_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic [3:0]       sel_q, sel_d;
    op_e              op_q, op_d;
    logic             res_valid_q, res_valid_d;
    logic             res_y_q, res_y_d;
    op_e              res_op_q, res_op_d;
    logic [CNT_W-1:0] ops_done_q, ops_done_d;

    logic fifo_full;
    logic fifo_empty;
    logic pop;
    cmd_t head;
    cmd_t in_cmd;

    assign in_cmd = '{op: op_e'(in_op), a: in_a, b: in_b};

    logic_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_valid),
        .wdata_i (in_cmd),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Deliberately independent of pop: a same-cycle pop never frees a slot early.
    assign in_ready = !fifo_full;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        op_d        = op_q;
        res_valid_d = res_valid_q;
        res_y_d     = res_y_q;
        res_op_d    = res_op_q;
        ops_done_d  = ops_done_q;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    a_d     = head.a;
                    b_d     = head.b;
                    sel_d   = op2sel(head.op);
                    op_d    = head.op;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                // Sel is live this cycle only, so Y is sampled here.
                res_y_d     = Y;
                res_op_d    = op_q;
                res_valid_d = 1'b1;
                a_d         = 1'b0;
                b_d         = 1'b0;
                sel_d       = 4'b0000;
                state_d     = RESULT;
            end
            RESULT: begin
                if (res_ready) begin
                    ops_done_d  = ops_done_q + CNT_W'(1);
                    res_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        a_d     = head.a;
                        b_d     = head.b;
                        sel_d   = op2sel(head.op);
                        op_d    = head.op;
                        state_d = DRIVE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            sel_q       <= 4'b0000;
            op_q        <= OP_NAND;
            res_valid_q <= 1'b0;
            res_y_q     <= 1'b0;
            res_op_q    <= OP_NAND;
            ops_done_q  <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            op_q        <= op_d;
            res_valid_q <= res_valid_d;
            res_y_q     <= res_y_d;
            res_op_q    <= res_op_d;
            ops_done_q  <= ops_done_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign Sel       = sel_q;
    assign res_valid = res_valid_q;
    assign res_y     = res_y_q;
    assign res_op    = res_op_q;
    assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// tb/tb_logic_op_sequencer.sv - self-checking bench for logic_op_sequencer

module tb_logic_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_op = 2'd0;
    logic        in_a = 1'b0;
    logic        in_b = 1'b0;
    logic        res_ready = 1'b0;

    logic        in_ready, A, B, Y, res_valid, res_y;
    logic [3:0]  Sel;
    logic [1:0]  res_op;
    logic [15:0] ops_done;

    logic        in_ready2, A2, B2, Y2, res_valid2, res_y2;
    logic [3:0]  Sel2;
    logic [1:0]  res_op2;
    logic [1:0]  ops_done2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Environment: the one-hot-select logic unit.
    function automatic logic unit_y(input logic [3:0] sel, input logic a, input logic b);
        case (sel)
            4'b0001: unit_y = !(a && b);
            4'b0010: unit_y = !(a || b);
            4'b0100: unit_y = a ^ b;
            4'b1000: unit_y = !(a ^ b);
            default: unit_y = 1'b0;
        endcase
    endfunction

    // Reference: expected result for a command.
    function automatic logic ref_y(input logic [1:0] op, input logic a, input logic b);
        case (op)
            2'd0:    ref_y = !(a && b);
            2'd1:    ref_y = !(a || b);
            2'd2:    ref_y = (a != b);
            default: ref_y = (a == b);
        endcase
    endfunction

    assign Y  = unit_y(Sel, A, B);
    assign Y2 = unit_y(Sel2, A2, B2);

    logic_op_sequencer #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .A(A), .B(B), .Sel(Sel), .Y(Y),
        .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
        .res_op(res_op), .ops_done(ops_done)
    );

    logic_op_sequencer #(.DEPTH(4), .CNT_W(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .A(A2), .B(B2), .Sel(Sel2), .Y(Y2),
        .res_valid(res_valid2), .res_ready(res_ready), .res_y(res_y2),
        .res_op(res_op2), .ops_done(ops_done2)
    );

    task automatic do_reset();
        in_valid  = 1'b0;
        res_ready = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({A, B, Sel, res_valid, res_y, res_op, in_ready} !== {1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1})
            $display("FAIL reset_outputs: got %b required %b",
                     {A, B, Sel, res_valid, res_y, res_op, in_ready}, 11'b00000000001);
        else passed++;
        total++;
        if (ops_done !== 16'd0 || ops_done2 !== 2'd0)
            $display("FAIL reset_ops_done: got %0d/%0d required 0/0", ops_done, ops_done2);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        do_reset();
        res_ready = 1'b1;
        in_valid = 1'b1; in_op = 2'd2; in_a = 1'b1; in_b = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (Sel !== 4'b0000) $display("FAIL single_sel_early: got %b required 0000", Sel);
        else passed++;
        @(negedge clk);
        total++;
        if ({Sel, A, B} !== {4'b0100, 1'b1, 1'b0})
            $display("FAIL single_drive: got %b required 010010", {Sel, A, B});
        else passed++;
        @(negedge clk);
        total++;
        if ({Sel, res_valid, res_y, res_op} !== {4'b0000, 1'b1, 1'b1, 2'd2})
            $display("FAIL single_result: got %b required 00001110", {Sel, res_valid, res_y, res_op});
        else passed++;
        @(negedge clk);
        total++;
        if (ops_done !== 16'd1 || res_valid !== 1'b0)
            $display("FAIL single_done: got ops=%0d valid=%b required ops=1 valid=0", ops_done, res_valid);
        else passed++;
    endtask

    task automatic test_all_ops();
        logic [15:0] sels = '0;
        logic [3:0]  ys = '0;
        int          nsel = 0, ny = 0;
        logic        prev_nz = 1'b0, adj_bad = 1'b0;
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (Sel != 4'b0000) begin
                if (prev_nz) adj_bad = 1'b1;
                sels = {sels[11:0], Sel};
                nsel++;
            end
            prev_nz = (Sel != 4'b0000);
            if (res_valid && res_ready) begin
                ys = {ys[2:0], res_y};
                ny++;
            end
            if (i < 4) begin
                in_valid = 1'b1; in_op = 2'(i); in_a = 1'b1; in_b = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        total++;
        if (nsel != 4 || sels !== 16'h1248)
            $display("FAIL allops_sel_seq: got n=%0d seq=%h required n=4 seq=1248", nsel, sels);
        else passed++;
        total++;
        if (ny != 4 || ys !== 4'b0001)
            $display("FAIL allops_res_seq: got n=%0d seq=%b required n=4 seq=0001", ny, ys);
        else passed++;
        total++;
        if (adj_bad !== 1'b0) $display("FAIL allops_sel_gap: got adjacent=1 required 0");
        else passed++;
    endtask

    task automatic test_full();
        logic [2:0] exp_res [5];
        logic [2:0] hold;
        logic       ready_bad = 1'b0, stable_bad = 1'b0;
        int         n = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (in_ready !== 1'b1) ready_bad = 1'b1;
            in_valid = 1'b1;
            in_op = 2'($urandom_range(0, 3)); in_a = 1'($urandom_range(0, 1)); in_b = 1'($urandom_range(0, 1));
            exp_res[i] = {in_op, ref_y(in_op, in_a, in_b)};
            @(negedge clk);
        end
        total++;
        if (ready_bad !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL full_ready_drop: got early_low=%b final=%b required 0 0", ready_bad, in_ready);
        else passed++;
        in_op = 2'd3; in_a = 1'b0; in_b = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0) $display("FAIL full_sixth_refused: got in_ready=%b required 0", in_ready);
        else passed++;
        hold = {res_op, res_y};
        total++;
        if (res_valid !== 1'b1 || hold !== exp_res[0])
            $display("FAIL full_first_held: got valid=%b res=%b required 1 %b", res_valid, hold, exp_res[0]);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || {res_op, res_y} !== hold || Sel !== 4'b0000) stable_bad = 1'b1;
        end
        total++;
        if (stable_bad !== 1'b0) $display("FAIL full_stable: got unstable=1 required 0");
        else passed++;
        res_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (res_valid) begin
                if (n < 5) begin
                    total++;
                    if ({res_op, res_y} !== exp_res[n])
                        $display("FAIL full_result%0d: got %b required %b", n, {res_op, res_y}, exp_res[n]);
                    else passed++;
                end
                n++;
            end
            @(negedge clk);
        end
        total++;
        if (n != 5 || ops_done !== 16'd5)
            $display("FAIL full_count: got results=%0d ops=%0d required 5 5", n, ops_done);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic bad = 1'b0;
        do_reset();
        in_valid = 1'b1; in_op = 2'd0; in_a = 1'b1; in_b = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (res_valid !== 1'b1) $display("FAIL bp_first_valid: got %b required 1", res_valid);
        else passed++;
        in_valid = 1'b1; in_op = 2'd3; in_a = 1'b0; in_b = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (Sel !== 4'b0000 || res_valid !== 1'b1 || {res_op, res_y} !== 3'b001) bad = 1'b1;
            if (k == 2) res_ready = 1'b1;
            @(negedge clk);
        end
        total++;
        if (bad !== 1'b0) $display("FAIL bp_hold: got early_pop_or_change=1 required 0");
        else passed++;
        total++;
        if ({Sel, A, B, res_valid} !== {4'b1000, 1'b0, 1'b1, 1'b0})
            $display("FAIL bp_accept_edge: got %b required 1000010", {Sel, A, B, res_valid});
        else passed++;
        @(negedge clk);
        total++;
        if ({res_valid, res_op, res_y} !== {1'b1, 2'd3, 1'b0})
            $display("FAIL bp_second_result: got %b required 1110", {res_valid, res_op, res_y});
        else passed++;
        @(negedge clk);
        total++;
        if (ops_done !== 16'd2) $display("FAIL bp_ops_done: got %0d required 2", ops_done);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic found = 1'b0, ghost = 1'b0;
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            if (Sel === 4'b0010) found = 1'b1;
            else begin
                in_valid = (i < 3);
                in_op = 2'(i); in_a = 1'b0; in_b = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        total++;
        if (found !== 1'b1 || ops_done !== 16'd1)
            $display("FAIL rmid_reach_drive: got found=%b ops=%0d required 1 1", found, ops_done);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({A, B, Sel, res_valid, res_y, res_op, in_ready} !== {1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1}
            || ops_done !== 16'd0)
            $display("FAIL rmid_async: got %b ops=%0d required 00000000001 ops=0",
                     {A, B, Sel, res_valid, res_y, res_op, in_ready}, ops_done);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || Sel !== 4'b0000) ghost = 1'b1;
        end
        total++;
        if (ghost !== 1'b0) $display("FAIL rmid_discarded: got ghost_activity=1 required 0");
        else passed++;
    endtask

    task automatic test_wrap();
        int pushed = 0;
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_valid = (pushed < 5);
            in_op = 2'($urandom_range(0, 3)); in_a = 1'($urandom_range(0, 1)); in_b = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) pushed++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++;
        if (ops_done !== 16'd5 || ops_done2 !== 2'd1)
            $display("FAIL wrap_count: got wide=%0d narrow=%0d required 5 1", ops_done, ops_done2);
        else passed++;
    endtask

    task automatic test_random();
        logic [2:0] exp_q [$];
        logic [2:0] want;
        logic [2:0] pres = '0;
        logic       pv = 1'b0, pr = 1'b0, ps = 1'b0;
        int         acc = 0;
        do_reset();
        for (int cyc = 0; cyc < 420; cyc++) begin
            total++;
            if (!(Sel == 4'b0000 || $onehot(Sel)) || (ps && Sel != 4'b0000))
                $display("FAIL rand_sel_shape: got %b prev_nonzero=%b required one-hot/zero, no repeat", Sel, ps);
            else passed++;
            if (pv && !pr) begin
                total++;
                if (res_valid !== 1'b1 || {res_op, res_y} !== pres)
                    $display("FAIL rand_hold: got valid=%b res=%b required 1 %b", res_valid, {res_op, res_y}, pres);
                else passed++;
            end
            if (cyc < 320) begin
                in_valid  = ($urandom_range(0, 99) < 60);
                res_ready = ($urandom_range(0, 99) < 50);
            end else begin
                in_valid  = 1'b0;
                res_ready = 1'b1;
            end
            in_op = 2'($urandom_range(0, 3)); in_a = 1'($urandom_range(0, 1)); in_b = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) exp_q.push_back({in_op, ref_y(in_op, in_a, in_b)});
            if (res_valid && res_ready) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bxxx;
                total++;
                if ({res_op, res_y} !== want)
                    $display("FAIL rand_result%0d: got %b required %b", acc, {res_op, res_y}, want);
                else passed++;
                acc++;
            end
            pv = res_valid; pr = res_ready; pres = {res_op, res_y}; ps = (Sel != 4'b0000);
            @(negedge clk);
        end
        total++;
        if (exp_q.size() != 0 || res_valid !== 1'b0 || ops_done !== 16'(acc))
            $display("FAIL rand_drain: got left=%0d valid=%b ops=%0d required 0 0 %0d",
                     exp_q.size(), res_valid, ops_done, acc);
        else passed++;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_all_ops();
        test_full();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
